// File: rtl/pot_pkg.sv
// pot_pkg: shared constants and types for the POKEY potentiometer scan.
//   POT_MAX_DEF    - default terminal count of a scan
//   POT_CENTRE_DEF - default target for a channel without a valid analog input
//   POT_SCALE      - multiplier that maps the 0..255 offset axis onto 0..224
package pot_pkg;

  localparam int POT_MAX_DEF    = 228;
  localparam int POT_CENTRE_DEF = 114;
  localparam int POT_SCALE      = 225;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } pot_state_t;

  typedef logic [7:0] pot_val_t;

endpackage : pot_pkg

// File: rtl/pot_map.sv
// pot_map: combinational conversion of one signed analog axis into a POKEY
// pot target count.
//   axis   in  8  signed axis value, -128..127
//   ena    in  1  analog valid; low forces POT_CENTRE
//   target out 8  pot count the scan should stop at (1..225, or POT_CENTRE)
module pot_map
  import pot_pkg::*;
#(
  parameter int POT_CENTRE = POT_CENTRE_DEF
) (
  input  logic [7:0] axis,
  input  logic       ena,
  output pot_val_t   target
);

  logic [7:0]  offset;
  logic [15:0] product;

  always_comb begin
    // Adding 128 to a two's-complement byte is the same as flipping its MSB.
    offset  = axis ^ 8'h80;
    product = {8'd0, offset} * 16'(POT_SCALE);
    if (ena) begin
      target = 8'(product >> 8) + 8'd1;
    end else begin
      target = pot_val_t'(POT_CENTRE);
    end
  end

endmodule : pot_map

// File: rtl/pot_scan.sv
// pot_scan: POKEY potentiometer scan emulation for four analog channels.
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   line_tick  in   1  one-cycle strobe per scanline (slow-scan count enable)
//   fast_scan  in   1  fast-pot mode: counter advances every clock
//   potgo      in   1  one-cycle strobe that starts or restarts a scan
//   axis0..3   in   8  signed axis values (JOY1X, JOY1Y, JOY2X, JOY2Y)
//   axis_ena   in   4  per-channel analog valid
//   pot0..3    out  8  pot readback values
//   allpot     out  4  bit n set while channel n is still counting
//   busy       out  1  scan in progress
module pot_scan
  import pot_pkg::*;
#(
  parameter int POT_MAX    = POT_MAX_DEF,
  parameter int POT_CENTRE = POT_CENTRE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_tick,
  input  logic       fast_scan,
  input  logic       potgo,
  input  logic [7:0] axis0,
  input  logic [7:0] axis1,
  input  logic [7:0] axis2,
  input  logic [7:0] axis3,
  input  logic [3:0] axis_ena,
  output pot_val_t   pot0,
  output pot_val_t   pot1,
  output pot_val_t   pot2,
  output pot_val_t   pot3,
  output logic [3:0] allpot,
  output logic       busy
);

  localparam pot_val_t POT_MAX_V = pot_val_t'(POT_MAX);

  pot_state_t state_q, state_d;
  pot_val_t   cnt_q, cnt_d;
  pot_val_t   tgt_q [4];
  pot_val_t   tgt_d [4];
  pot_val_t   pot_q [4];
  pot_val_t   pot_d [4];
  logic [3:0] allpot_q, allpot_d;

  logic [7:0] axis_in [4];
  pot_val_t   tgt_new [4];
  pot_val_t   cnt_next;
  logic       cnt_en;

  assign axis_in[0] = axis0;
  assign axis_in[1] = axis1;
  assign axis_in[2] = axis2;
  assign axis_in[3] = axis3;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_map
      pot_map #(
        .POT_CENTRE(POT_CENTRE)
      ) u_map (
        .axis  (axis_in[gi]),
        .ena   (axis_ena[gi]),
        .target(tgt_new[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    pot_d    = pot_q;
    allpot_d = allpot_q;
    cnt_next = cnt_q + 8'd1;
    cnt_en   = fast_scan | line_tick;

    if (potgo) begin
      // A start strobe always wins over a same-cycle count enable, and
      // discards any partial results of a scan already in progress.
      state_d  = SCAN;
      cnt_d    = '0;
      tgt_d    = tgt_new;
      pot_d    = '{default: '0};
      allpot_d = 4'hF;
    end else if (state_q == SCAN && cnt_en) begin
      cnt_d = cnt_next;
      for (int n = 0; n < 4; n++) begin
        if (allpot_q[n]) begin
          // Running channels show the live count; the value at the moment
          // the target (or terminal count) is reached is what stays latched.
          pot_d[n] = cnt_next;
          if (cnt_next >= tgt_q[n] || cnt_next == POT_MAX_V) begin
            allpot_d[n] = 1'b0;
          end
        end
      end
      if (allpot_d == 4'h0 || cnt_next == POT_MAX_V) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgt_q    <= '{default: '0};
      pot_q    <= '{default: '0};
      allpot_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      pot_q    <= pot_d;
      allpot_q <= allpot_d;
    end
  end

  assign pot0   = pot_q[0];
  assign pot1   = pot_q[1];
  assign pot2   = pot_q[2];
  assign pot3   = pot_q[3];
  assign allpot = allpot_q;
  assign busy   = (state_q == SCAN);

endmodule : pot_scan

// File: tb/tb_pot_scan.sv
// tb_pot_scan: directed self-checking bench for pot_scan. A second instance
// with a reduced terminal count (200) lets a reachable target (225) sit above
// the terminal count, exercising the forced latch at the end of a scan.
module tb_pot_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_tick = 1'b0;
  logic       fast_scan = 1'b0;
  logic       potgo = 1'b0;
  logic [7:0] axis0 = 8'h00;
  logic [7:0] axis1 = 8'h00;
  logic [7:0] axis2 = 8'h00;
  logic [7:0] axis3 = 8'h00;
  logic [3:0] axis_ena = 4'h0;

  logic [7:0] pot0, pot1, pot2, pot3;
  logic [3:0] allpot;
  logic       busy;
  logic [7:0] lim_pot0, lim_pot1, lim_pot2, lim_pot3;
  logic [3:0] lim_allpot;
  logic       lim_busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pot_scan dut (
    .clk(clk), .rst_n(rst_n), .line_tick(line_tick), .fast_scan(fast_scan),
    .potgo(potgo), .axis0(axis0), .axis1(axis1), .axis2(axis2), .axis3(axis3),
    .axis_ena(axis_ena), .pot0(pot0), .pot1(pot1), .pot2(pot2), .pot3(pot3),
    .allpot(allpot), .busy(busy)
  );

  pot_scan #(.POT_MAX(200), .POT_CENTRE(114)) dut_lim (
    .clk(clk), .rst_n(rst_n), .line_tick(line_tick), .fast_scan(fast_scan),
    .potgo(potgo), .axis0(axis0), .axis1(axis1), .axis2(axis2), .axis3(axis3),
    .axis_ena(axis_ena), .pot0(lim_pot0), .pot1(lim_pot1), .pot2(lim_pot2),
    .pot3(lim_pot3), .allpot(lim_allpot), .busy(lim_busy)
  );

  // Advance n clock edges; outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_scan();
    potgo = 1'b1;
    tick();
    potgo = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    tests_run++; if (pot0 !== 8'd0 || pot1 !== 8'd0 || pot2 !== 8'd0 || pot3 !== 8'd0) begin tests_failed++; $display("FAIL reset_pots: got %0d %0d %0d %0d expected 0 0 0 0", pot0, pot1, pot2, pot3); end
    tests_run++; if (allpot !== 4'h0) begin tests_failed++; $display("FAIL reset_allpot: got %h expected 0", allpot); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      line_tick = 1'b1;
      tick();
      line_tick = 1'b0;
      tick();
    end
    tests_run++; if (pot0 !== 8'd0 || allpot !== 4'h0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_ticks: got pot0=%0d allpot=%h busy=%b expected 0 0 0", pot0, allpot, busy); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_fast_scan();
    axis0 = 8'h00; axis1 = 8'h80; axis2 = 8'h7F; axis3 = 8'h00;
    axis_ena = 4'b0111;
    fast_scan = 1'b1;
    start_scan();
    tests_run++; if (busy !== 1'b1 || allpot !== 4'hF || pot0 !== 8'd0) begin tests_failed++; $display("FAIL fast_start: got busy=%b allpot=%h pot0=%0d expected 1 f 0", busy, allpot, pot0); end
    tick();  // cycle 1
    tests_run++; if (pot1 !== 8'd1 || allpot !== 4'b1101) begin tests_failed++; $display("FAIL fast_ch1_latch: got pot1=%0d allpot=%b expected 1 1101", pot1, allpot); end
    tests_run++; if (pot0 !== 8'd1) begin tests_failed++; $display("FAIL fast_running: got pot0=%0d expected 1", pot0); end
    tick(111);  // cycle 112
    tests_run++; if (pot0 !== 8'd112 || allpot[0] !== 1'b1) begin tests_failed++; $display("FAIL fast_ch0_before: got pot0=%0d allpot0=%b expected 112 1", pot0, allpot[0]); end
    tick();  // cycle 113
    tests_run++; if (pot0 !== 8'd113 || allpot !== 4'b1100) begin tests_failed++; $display("FAIL fast_ch0_latch: got pot0=%0d allpot=%b expected 113 1100", pot0, allpot); end
    tick();  // cycle 114
    tests_run++; if (pot3 !== 8'd114 || allpot !== 4'b0100) begin tests_failed++; $display("FAIL fast_ch3_centre: got pot3=%0d allpot=%b expected 114 0100", pot3, allpot); end
    tick(110);  // cycle 224
    tests_run++; if (busy !== 1'b1 || pot2 !== 8'd224) begin tests_failed++; $display("FAIL fast_before_end: got busy=%b pot2=%0d expected 1 224", busy, pot2); end
    tick();  // cycle 225
    tests_run++; if (busy !== 1'b0 || allpot !== 4'h0 || pot2 !== 8'd225) begin tests_failed++; $display("FAIL fast_end: got busy=%b allpot=%h pot2=%0d expected 0 0 225", busy, allpot, pot2); end
    tick(5);
    tests_run++; if (pot0 !== 8'd113 || pot1 !== 8'd1 || pot2 !== 8'd225 || pot3 !== 8'd114) begin tests_failed++; $display("FAIL fast_hold: got %0d %0d %0d %0d expected 113 1 225 114", pot0, pot1, pot2, pot3); end
    $display("[TB] test_fast_scan done");
  endtask

  task automatic test_slow_scan();
    axis0 = 8'h00;
    axis_ena = 4'b0001;
    fast_scan = 1'b0;
    start_scan();
    for (int k = 1; k <= 113; k++) begin
      tick(9);
      if (k == 50) begin
        tests_run++; if (pot0 !== 8'd49) begin tests_failed++; $display("FAIL slow_between_ticks: got pot0=%0d expected 49", pot0); end
      end
      line_tick = 1'b1;
      tick();
      line_tick = 1'b0;
      if (k == 1) begin
        tests_run++; if (pot0 !== 8'd1) begin tests_failed++; $display("FAIL slow_first_tick: got pot0=%0d expected 1", pot0); end
      end
      if (k == 112) begin
        tests_run++; if (pot0 !== 8'd112 || allpot[0] !== 1'b1) begin tests_failed++; $display("FAIL slow_tick112: got pot0=%0d allpot0=%b expected 112 1", pot0, allpot[0]); end
      end
      if (k == 113) begin
        tests_run++; if (pot0 !== 8'd113 || allpot !== 4'b1110) begin tests_failed++; $display("FAIL slow_tick113: got pot0=%0d allpot=%b expected 113 1110", pot0, allpot); end
      end
    end
    $display("[TB] test_slow_scan done");
  endtask

  task automatic test_pot_max();
    axis2 = 8'h7F;
    axis_ena = 4'b0100;
    fast_scan = 1'b1;
    start_scan();
    tick(199);
    tests_run++; if (lim_busy !== 1'b1 || lim_allpot !== 4'b0100 || lim_pot2 !== 8'd199) begin tests_failed++; $display("FAIL max_before: got busy=%b allpot=%b pot2=%0d expected 1 0100 199", lim_busy, lim_allpot, lim_pot2); end
    tick();
    tests_run++; if (lim_busy !== 1'b0 || lim_allpot !== 4'h0 || lim_pot2 !== 8'd200) begin tests_failed++; $display("FAIL max_latch: got busy=%b allpot=%h pot2=%0d expected 0 0 200", lim_busy, lim_allpot, lim_pot2); end
    tests_run++; if (busy !== 1'b1 || allpot !== 4'b0100) begin tests_failed++; $display("FAIL max_default_running: got busy=%b allpot=%b expected 1 0100", busy, allpot); end
    tick(30);
    $display("[TB] test_pot_max done");
  endtask

  task automatic test_restart();
    axis0 = 8'h00; axis1 = 8'h00; axis2 = 8'h00; axis3 = 8'h00;
    axis_ena = 4'hF;
    fast_scan = 1'b1;
    start_scan();
    tick(50);
    tests_run++; if (pot0 !== 8'd50) begin tests_failed++; $display("FAIL restart_count50: got pot0=%0d expected 50", pot0); end
    axis0 = 8'h80;
    start_scan();
    tests_run++; if (pot0 !== 8'd0 || allpot !== 4'hF || busy !== 1'b1) begin tests_failed++; $display("FAIL restart_clear: got pot0=%0d allpot=%h busy=%b expected 0 f 1", pot0, allpot, busy); end
    tick();
    tests_run++; if (pot0 !== 8'd1 || allpot !== 4'b1110 || pot1 !== 8'd1) begin tests_failed++; $display("FAIL restart_latch: got pot0=%0d allpot=%b pot1=%0d expected 1 1110 1", pot0, allpot, pot1); end
    tick(5);
    fast_scan = 1'b0;
    line_tick = 1'b1;
    potgo = 1'b1;
    tick();
    potgo = 1'b0;
    line_tick = 1'b0;
    tests_run++; if (pot1 !== 8'd0 || allpot !== 4'hF) begin tests_failed++; $display("FAIL potgo_tick_collide: got pot1=%0d allpot=%h expected 0 f", pot1, allpot); end
    line_tick = 1'b1;
    tick();
    line_tick = 1'b0;
    tests_run++; if (pot1 !== 8'd1 || pot0 !== 8'd1 || allpot !== 4'b1110) begin tests_failed++; $display("FAIL collide_next_tick: got pot1=%0d pot0=%0d allpot=%b expected 1 1 1110", pot1, pot0, allpot); end
    $display("[TB] test_restart done");
  endtask

  task automatic test_reset_mid();
    axis0 = 8'h00;
    axis_ena = 4'hF;
    fast_scan = 1'b1;
    start_scan();
    tick(20);
    rst_n = 1'b0;
    #2;  // well before the next clock edge
    tests_run++; if (pot0 !== 8'd0 || allpot !== 4'h0 || busy !== 1'b0) begin tests_failed++; $display("FAIL async_reset: got pot0=%0d allpot=%h busy=%b expected 0 0 0", pot0, allpot, busy); end
    tick(2);
    rst_n = 1'b1;
    tick(10);
    tests_run++; if (pot0 !== 8'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL no_resume: got pot0=%0d busy=%b expected 0 0", pot0, busy); end
    start_scan();
    tick(5);
    tests_run++; if (pot0 !== 8'd5 || busy !== 1'b1) begin tests_failed++; $display("FAIL rescan_after_reset: got pot0=%0d busy=%b expected 5 1", pot0, busy); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_fast_scan();
    test_slow_scan();
    test_pot_max();
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pot_scan
